// File: rtl/multiface_pkg.sv
// Shared types and shadow-register RAM offsets for the Multiface freezer controller.
package multiface_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPend,
      StAct,
      StActH,
      StHid
   } mf_state_t;

   // 13-bit offsets within the top 8 KB of the private RAM where write-only registers are mirrored
   localparam logic [12:0] OFF_PEN_SEL   = 13'h1FCF;
   localparam logic [12:0] OFF_PEN_BASE  = 13'h1F90;
   localparam logic [12:0] OFF_BORDER    = 13'h1FDF;
   localparam logic [12:0] OFF_MODE      = 13'h1FEF;
   localparam logic [12:0] OFF_BANK      = 13'h1FFF;
   localparam logic [12:0] OFF_CRTC_SEL  = 13'h1CFF;
   localparam logic [12:0] OFF_CRTC_BASE = 13'h1DB0;
   localparam logic [12:0] OFF_PPI       = 13'h17FF;
   localparam logic [12:0] OFF_UROM      = 13'h1AAC;

endpackage

// File: rtl/multiface_ram.sv
// Synchronous single-port RAM with a registered read port (one-cycle latency).
module multiface_ram #(
   parameter int unsigned AW = 13,
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);

   logic [DW-1:0] mem [0:(2**AW)-1];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= din;
   end

   // Read-first: a read coinciding with a write returns the old contents
   always_ff @(posedge clk or posedge rst) begin
      if (rst) dout <= '0;
      else     dout <= mem[addr];
   end

endmodule

// File: rtl/multiface_ctrl.sv
// Multiface NMI-freezer controller: NMI trap FSM, page port, hidden latch and private RAM.
// Define MULTIFACE_SHADOW_EN to mirror write-only hardware registers into the RAM.
module multiface_ctrl
   import multiface_pkg::*;
#(
   parameter int unsigned RAM_AW    = 13,
   parameter logic [15:0] NMI_VEC   = 16'h0066,
   parameter logic [15:0] HIDE_VEC  = 16'h0065,
   parameter logic [15:0] PORT_BASE = 16'hFEE8,
   parameter int unsigned HOLDOFF   = 4096
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  io_dout,
   input  logic        m1,
   input  logic        io_wr,
   input  logic        mem_wr,
   input  logic        key_nmi,
   output logic        nmi,
   output logic        mf_en,
   output logic        mf_rom_sel,
   output logic        mf_ram_sel,
   output logic [7:0]  mf_ram_dout,
   output logic        mf_hidden
);

   localparam int unsigned HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
   localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF);

   mf_state_t       state_q, state_d;
   logic [HO_W-1:0] holdoff_q, holdoff_d;
   logic            m1_q, io_wr_q, key_q;
   logic            rise_m1, rise_io_wr, rise_key;
   logic            port_hit, page_in, page_out, key_ok;
   logic            act_q, act_d;

   assign rise_m1    = m1 & ~m1_q;
   assign rise_io_wr = io_wr & ~io_wr_q;
   assign rise_key   = key_nmi & ~key_q;

   assign port_hit = rise_io_wr && (cpu_addr[15:2] == PORT_BASE[15:2]);
   assign page_out = port_hit & cpu_addr[1];
   assign page_in  = port_hit & ~cpu_addr[1];
   assign key_ok   = rise_key && (holdoff_q == '0);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         holdoff_q <= '0;
         m1_q      <= 1'b0;
         io_wr_q   <= 1'b0;
         key_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         holdoff_q <= holdoff_d;
         m1_q      <= m1;
         io_wr_q   <= io_wr;
         key_q     <= key_nmi;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (key_ok)       state_d = StPend;
            else if (page_in) state_d = StAct;
         end
         StHid: if (key_ok) state_d = StPend;
         StPend: if (rise_m1 && cpu_addr == NMI_VEC) state_d = StAct;
         StAct: begin
            if (page_out)                              state_d = StIdle;
            else if (rise_m1 && cpu_addr == HIDE_VEC)  state_d = StActH;
         end
         StActH: if (page_out) state_d = StHid;
         default: state_d = StIdle;
      endcase
   end

   // Hold-off restarts whenever the freezer pages itself out
   assign act_q = (state_q == StAct) || (state_q == StActH);
   assign act_d = (state_d == StAct) || (state_d == StActH);

   always_comb begin
      holdoff_d = holdoff_q;
      if (act_q && !act_d)        holdoff_d = HO_LOAD;
      else if (holdoff_q != '0)   holdoff_d = holdoff_q - HO_W'(1);
   end

   always_comb begin
      nmi       = 1'b0;
      mf_en     = 1'b0;
      mf_hidden = 1'b0;
      unique case (state_q)
         StPend: nmi = 1'b1;
         StAct:  mf_en = 1'b1;
         StActH: begin
            mf_en     = 1'b1;
            mf_hidden = 1'b1;
         end
         StHid:  mf_hidden = 1'b1;
         default: ;
      endcase
   end

   assign mf_rom_sel = mf_en && (cpu_addr[15:13] == 3'b000);
   assign mf_ram_sel = mf_en && (cpu_addr[15:13] == 3'b001);

   logic        cpu_we, cap_we, ram_we;
   logic [12:0] cap_off;
   logic [RAM_AW-1:0] ram_addr;

   assign cpu_we = mem_wr & mf_ram_sel;

`ifdef MULTIFACE_SHADOW_EN
   logic [4:0] pen_q;
   logic [3:0] crtc_reg_q;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         pen_q      <= '0;
         crtc_reg_q <= '0;
      end else if (rise_io_wr) begin
         if (cpu_addr[15:8] == 8'h7F && io_dout[7:6] == 2'b00) pen_q <= io_dout[4:0];
         if (cpu_addr[15:8] == 8'hBC) crtc_reg_q <= io_dout[3:0];
      end
   end

   always_comb begin
      cap_we  = 1'b0;
      cap_off = OFF_BANK;
      if (rise_io_wr) begin
         case (cpu_addr[15:8])
            8'h7F: begin
               cap_we = 1'b1;
               case (io_dout[7:6])
                  2'b00:   cap_off = OFF_PEN_SEL;
                  2'b01:   cap_off = pen_q[4] ? OFF_BORDER : OFF_PEN_BASE + {9'd0, pen_q[3:0]};
                  2'b10:   cap_off = OFF_MODE;
                  default: cap_off = OFF_BANK;
               endcase
            end
            8'hBC: begin cap_we = 1'b1; cap_off = OFF_CRTC_SEL; end
            8'hBD: begin cap_we = 1'b1; cap_off = OFF_CRTC_BASE + {9'd0, crtc_reg_q}; end
            8'hF7: begin cap_we = 1'b1; cap_off = OFF_PPI; end
            8'hDF: begin cap_we = 1'b1; cap_off = OFF_UROM; end
            default: ;
         endcase
      end
   end

   // A Z80 cannot issue an OUT and a memory write in the same cycle
   assert property (@(posedge clk_sys) disable iff (reset) !(cap_we && cpu_we));
`else
   assign cap_we  = 1'b0;
   assign cap_off = '0;
`endif

   // Capture wins over a CPU write; upper address bits of a capture are all ones
   always_comb begin
      ram_addr       = '0;
      ram_addr[12:0] = cpu_addr[12:0];
      ram_we         = cpu_we;
      if (cap_we) begin
         ram_addr       = '1;
         ram_addr[12:0] = cap_off;
         ram_we         = 1'b1;
      end
   end

   multiface_ram #(
      .AW (RAM_AW),
      .DW (8)
   ) u_ram (
      .clk  (clk_sys),
      .rst  (reset),
      .we   (ram_we),
      .addr (ram_addr),
      .din  (io_dout),
      .dout (mf_ram_dout)
   );

endmodule

// File: tb/tb_multiface_ctrl.sv
// Directed self-checking bench for multiface_ctrl (default parameters).
module tb_multiface_ctrl;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic [15:0] cpu_addr;
   logic [7:0]  io_dout;
   logic        m1, io_wr, mem_wr, key_nmi;
   logic        nmi, mf_en, mf_rom_sel, mf_ram_sel, mf_hidden;
   logic [7:0]  mf_ram_dout;

   int n_vec = 0;
   int n_err = 0;

   multiface_ctrl dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .cpu_addr    (cpu_addr),
      .io_dout     (io_dout),
      .m1          (m1),
      .io_wr       (io_wr),
      .mem_wr      (mem_wr),
      .key_nmi     (key_nmi),
      .nmi         (nmi),
      .mf_en       (mf_en),
      .mf_rom_sel  (mf_rom_sel),
      .mf_ram_sel  (mf_ram_sel),
      .mf_ram_dout (mf_ram_dout),
      .mf_hidden   (mf_hidden)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic io_out(input logic [15:0] a, input logic [7:0] d);
      cpu_addr = a; io_dout = d; io_wr = 1'b1;
      tick();
      io_wr = 1'b0;
      tick();
   endtask

   task automatic mwrite(input logic [15:0] a, input logic [7:0] d);
      cpu_addr = a; io_dout = d; mem_wr = 1'b1;
      tick();
      mem_wr = 1'b0;
   endtask

   task automatic m1_fetch(input logic [15:0] a);
      cpu_addr = a; m1 = 1'b1;
      tick();
      m1 = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; cpu_addr = 16'h0000; io_dout = 8'h00;
      m1 = 1'b0; io_wr = 1'b0; mem_wr = 1'b0; key_nmi = 1'b0;
      tick(); tick();
      n_vec++; if (nmi !== 1'b0) begin n_err++; $display("FAIL reset_nmi: got %b want 0", nmi); end
      n_vec++; if (mf_en !== 1'b0) begin n_err++; $display("FAIL reset_mf_en: got %b want 0", mf_en); end
      n_vec++; if (mf_hidden !== 1'b0) begin n_err++; $display("FAIL reset_hidden: got %b want 0", mf_hidden); end
      n_vec++; if (mf_ram_dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", mf_ram_dout); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_nmi_trap();
      key_nmi = 1'b1;
      tick();
      n_vec++; if (nmi !== 1'b1) begin n_err++; $display("FAIL trap_nmi_req: got %b want 1", nmi); end
      key_nmi = 1'b0;
      tick();
      cpu_addr = 16'h0067; m1 = 1'b1;
      tick();
      n_vec++; if (nmi !== 1'b1) begin n_err++; $display("FAIL trap_wrong_vec_nmi: got %b want 1", nmi); end
      n_vec++; if (mf_en !== 1'b0) begin n_err++; $display("FAIL trap_wrong_vec_en: got %b want 0", mf_en); end
      m1 = 1'b0;
      tick();
      m1_fetch(16'h0066);
      n_vec++; if (nmi !== 1'b0) begin n_err++; $display("FAIL trap_nmi_clr: got %b want 0", nmi); end
      n_vec++; if (mf_en !== 1'b1) begin n_err++; $display("FAIL trap_mf_en: got %b want 1", mf_en); end
      n_vec++; if (mf_rom_sel !== 1'b1) begin n_err++; $display("FAIL trap_rom_sel: got %b want 1", mf_rom_sel); end
   endtask

   task automatic test_ram();
      mwrite(16'h2123, 8'hA5);
      tick();
      n_vec++; if (mf_ram_dout !== 8'hA5) begin n_err++; $display("FAIL ram_rd: got %h want a5", mf_ram_dout); end
      mwrite(16'h2100, 8'h5A);
      cpu_addr = 16'h0100; io_dout = 8'h33; mem_wr = 1'b1;
      #1;
      n_vec++; if (mf_rom_sel !== 1'b1) begin n_err++; $display("FAIL rom_sel: got %b want 1", mf_rom_sel); end
      n_vec++; if (mf_ram_sel !== 1'b0) begin n_err++; $display("FAIL rom_ram_sel: got %b want 0", mf_ram_sel); end
      tick();
      mem_wr = 1'b0; cpu_addr = 16'h2100;
      tick();
      n_vec++; if (mf_ram_dout !== 8'h5A) begin n_err++; $display("FAIL rom_wr_blocked: got %h want 5a", mf_ram_dout); end
   endtask

   task automatic test_holdoff();
      cpu_addr = 16'hFEEA; io_wr = 1'b1;
      tick();
      io_wr = 1'b0;
      n_vec++; if (mf_en !== 1'b0) begin n_err++; $display("FAIL pageout_en: got %b want 0", mf_en); end
      for (int k = 1; k <= 4095; k++) begin
         key_nmi = (k == 100);
         tick();
         if (k == 100) begin
            n_vec++; if (nmi !== 1'b0) begin n_err++; $display("FAIL holdoff_early: got %b want 0", nmi); end
         end
      end
      key_nmi = 1'b1;
      tick();
      n_vec++; if (nmi !== 1'b0) begin n_err++; $display("FAIL holdoff_4096: got %b want 0", nmi); end
      key_nmi = 1'b0;
      tick();
      key_nmi = 1'b1;
      tick();
      n_vec++; if (nmi !== 1'b1) begin n_err++; $display("FAIL holdoff_expired: got %b want 1", nmi); end
      key_nmi = 1'b0;
      m1_fetch(16'h0066);
      n_vec++; if (mf_en !== 1'b1) begin n_err++; $display("FAIL holdoff_retrap: got %b want 1", mf_en); end
   endtask

   task automatic test_hidden();
      m1_fetch(16'h0065);
      n_vec++; if (mf_hidden !== 1'b1) begin n_err++; $display("FAIL hide_set: got %b want 1", mf_hidden); end
      n_vec++; if (mf_en !== 1'b1) begin n_err++; $display("FAIL hide_en: got %b want 1", mf_en); end
      io_out(16'hFEEA, 8'h00);
      n_vec++; if (mf_en !== 1'b0) begin n_err++; $display("FAIL hid_pageout: got %b want 0", mf_en); end
      io_out(16'hFEE8, 8'h00);
      n_vec++; if (mf_en !== 1'b0) begin n_err++; $display("FAIL hid_pagein_ignored: got %b want 0", mf_en); end
      n_vec++; if (mf_hidden !== 1'b1) begin n_err++; $display("FAIL hid_latched: got %b want 1", mf_hidden); end
      repeat (4100) tick();
      key_nmi = 1'b1;
      tick();
      key_nmi = 1'b0;
      n_vec++; if (nmi !== 1'b1) begin n_err++; $display("FAIL hid_nmi: got %b want 1", nmi); end
      tick();
      m1_fetch(16'h0066);
      n_vec++; if (mf_hidden !== 1'b0) begin n_err++; $display("FAIL hid_clr: got %b want 0", mf_hidden); end
      n_vec++; if (mf_en !== 1'b1) begin n_err++; $display("FAIL hid_retrap_en: got %b want 1", mf_en); end
   endtask

   task automatic test_shadow();
`ifdef MULTIFACE_SHADOW_EN
      io_out(16'h7F00, 8'h03);
      io_out(16'h7F00, 8'h4B);
      io_out(16'hBC00, 8'h0C);
      io_out(16'hBD00, 8'h30);
      io_out(16'hF700, 8'h82);
      cpu_addr = 16'h3FCF; tick();
      n_vec++; if (mf_ram_dout !== 8'h03) begin n_err++; $display("FAIL shadow_pen_sel: got %h want 03", mf_ram_dout); end
      cpu_addr = 16'h3F93; tick();
      n_vec++; if (mf_ram_dout !== 8'h4B) begin n_err++; $display("FAIL shadow_pen3: got %h want 4b", mf_ram_dout); end
      cpu_addr = 16'h3CFF; tick();
      n_vec++; if (mf_ram_dout !== 8'h0C) begin n_err++; $display("FAIL shadow_crtc_sel: got %h want 0c", mf_ram_dout); end
      cpu_addr = 16'h3DBC; tick();
      n_vec++; if (mf_ram_dout !== 8'h30) begin n_err++; $display("FAIL shadow_crtc_r12: got %h want 30", mf_ram_dout); end
      cpu_addr = 16'h37FF; tick();
      n_vec++; if (mf_ram_dout !== 8'h82) begin n_err++; $display("FAIL shadow_ppi: got %h want 82", mf_ram_dout); end
`else
      mwrite(16'h3FCF, 8'h11);
      io_out(16'h7F00, 8'h03);
      cpu_addr = 16'h3FCF; tick();
      n_vec++; if (mf_ram_dout !== 8'h11) begin n_err++; $display("FAIL no_shadow: got %h want 11", mf_ram_dout); end
`endif
      n_vec++; if (mf_en !== 1'b1) begin n_err++; $display("FAIL shadow_en_kept: got %b want 1", mf_en); end
   endtask

   task automatic test_async_reset();
      reset = 1'b1; tick(); reset = 1'b0; tick();
      io_out(16'hFEE8, 8'h00);
      n_vec++; if (mf_en !== 1'b1) begin n_err++; $display("FAIL pagein: got %b want 1", mf_en); end
      m1_fetch(16'h0065);
      n_vec++; if (mf_hidden !== 1'b1) begin n_err++; $display("FAIL acth_hidden: got %b want 1", mf_hidden); end
      #2 reset = 1'b1;
      #1;
      n_vec++; if ({nmi, mf_en, mf_hidden} !== 3'b000) begin
         n_err++; $display("FAIL async_rst_acth: got %b want 000", {nmi, mf_en, mf_hidden});
      end
      tick(); reset = 1'b0; tick();
      key_nmi = 1'b1; tick(); key_nmi = 1'b0;
      n_vec++; if (nmi !== 1'b1) begin n_err++; $display("FAIL pend_nmi: got %b want 1", nmi); end
      #2 reset = 1'b1;
      #1;
      n_vec++; if ({nmi, mf_en, mf_hidden} !== 3'b000) begin
         n_err++; $display("FAIL async_rst_pend: got %b want 000", {nmi, mf_en, mf_hidden});
      end
      tick(); reset = 1'b0; tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_nmi_trap();
      test_ram();
      test_holdoff();
      test_hidden();
      test_shadow();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
